// File: rtl/cache_def.sv
// Shared types for the risk-check front end: ingress request records and arbiter FSM states.
package cache_def;

  typedef struct packed {
    logic [4:0]  client_id;
    logic [31:0] amount;
    logic        new_max;
  } cpu_order_t;

  typedef struct packed {
    logic [4:0]  client_id;
    logic [15:0] amount;
  } exch_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } ingress_state_t;

  localparam int unsigned CpuOrderW = $bits(cpu_order_t);
  localparam int unsigned ExchMsgW  = $bits(exch_msg_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two so the pointers wrap
// naturally; a push and a pop on the same edge are both honoured.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == (AW+1)'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/order_ingress_arbiter.sv
// Buffers CPU orders and exchange cancellations, then issues one request at a time to the risk
// stage. Exchange traffic wins, bounded by a starvation guard so queued CPU work still moves.
module order_ingress_arbiter
  import cache_def::*;
#(
  parameter int unsigned CPU_DEPTH    = 4,
  parameter int unsigned EXCH_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                        clk,
  input  logic                        HRESETn,
  input  logic                        cpu_valid,
  output logic                        cpu_ready,
  input  logic [4:0]                  cpu_client_id_i,
  input  logic [31:0]                 cpu_amount_i,
  input  logic                        cpu_new_max_i,
  input  logic                        exch_valid,
  output logic                        exch_ready,
  input  logic [4:0]                  exch_client_id_i,
  input  logic [15:0]                 exch_amount_i,
  output logic                        cpu_go,
  output logic                        cpu_new_max,
  output logic                        exchange_go,
  output logic [4:0]                  cpu_client_id,
  output logic [4:0]                  exchange_client_id,
  output logic [31:0]                 cpu_amount,
  output logic [15:0]                 exchange_amount,
  input  logic                        done,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [$clog2(CPU_DEPTH):0]  cpu_count,
  output logic [$clog2(EXCH_DEPTH):0] exch_count
);

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  cpu_order_t cpu_wdata, cpu_head;
  exch_msg_t  exch_wdata, exch_head;
  logic       cpu_full, cpu_empty, cpu_pop;
  logic       exch_full, exch_empty, exch_pop;

  assign cpu_wdata  = '{client_id: cpu_client_id_i, amount: cpu_amount_i,
                        new_max: cpu_new_max_i};
  assign exch_wdata = '{client_id: exch_client_id_i, amount: exch_amount_i};

  sync_fifo #(
    .WIDTH (CpuOrderW),
    .DEPTH (CPU_DEPTH)
  ) u_cpu_fifo (
    .clk_i   (clk),
    .rst_ni  (HRESETn),
    .push_i  (cpu_valid),
    .wdata_i (cpu_wdata),
    .pop_i   (cpu_pop),
    .rdata_o (cpu_head),
    .full_o  (cpu_full),
    .empty_o (cpu_empty),
    .count_o (cpu_count)
  );

  sync_fifo #(
    .WIDTH (ExchMsgW),
    .DEPTH (EXCH_DEPTH)
  ) u_exch_fifo (
    .clk_i   (clk),
    .rst_ni  (HRESETn),
    .push_i  (exch_valid),
    .wdata_i (exch_wdata),
    .pop_i   (exch_pop),
    .rdata_o (exch_head),
    .full_o  (exch_full),
    .empty_o (exch_empty),
    .count_o (exch_count)
  );

  assign cpu_ready  = !cpu_full;
  assign exch_ready = !exch_full;

  ingress_state_t state_q, state_d;
  logic           cpu_go_q, cpu_go_d;
  logic           cpu_nm_q, cpu_nm_d;
  logic           exch_go_q, exch_go_d;
  logic [4:0]     cpu_id_q, cpu_id_d;
  logic [31:0]    cpu_amt_q, cpu_amt_d;
  logic [4:0]     exch_id_q, exch_id_d;
  logic [15:0]    exch_amt_q, exch_amt_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           terr_q, terr_d;
  logic           starved, grant_exch;

  always_comb begin
    state_d    = state_q;
    cpu_go_d   = 1'b0;
    cpu_nm_d   = 1'b0;
    exch_go_d  = 1'b0;
    cpu_id_d   = cpu_id_q;
    cpu_amt_d  = cpu_amt_q;
    exch_id_d  = exch_id_q;
    exch_amt_d = exch_amt_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    terr_d     = terr_q;
    cpu_pop    = 1'b0;
    exch_pop   = 1'b0;

    starved    = (starve_q == SW'(STARVE_LIMIT));
    grant_exch = !exch_empty && !(starved && !cpu_empty);

    unique case (state_q)
      IDLE: begin
        if (!cpu_empty || !exch_empty) begin
          state_d = ISSUE;
          if (grant_exch) begin
            exch_pop   = 1'b1;
            exch_go_d  = 1'b1;
            exch_id_d  = exch_head.client_id;
            exch_amt_d = exch_head.amount;
            if (!cpu_empty && !starved) starve_d = starve_q + SW'(1);
          end else begin
            cpu_pop   = 1'b1;
            cpu_go_d  = 1'b1;
            cpu_nm_d  = cpu_head.new_max;
            cpu_id_d  = cpu_head.client_id;
            cpu_amt_d = cpu_head.amount;
            starve_d  = '0;
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = done ? IDLE : WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The guard only counts exchange wins that actually held CPU work back.
    if (cpu_empty) starve_d = '0;
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      cpu_go_q   <= 1'b0;
      cpu_nm_q   <= 1'b0;
      exch_go_q  <= 1'b0;
      cpu_id_q   <= '0;
      cpu_amt_q  <= '0;
      exch_id_q  <= '0;
      exch_amt_q <= '0;
      starve_q   <= '0;
      tmo_q      <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_go_q   <= cpu_go_d;
      cpu_nm_q   <= cpu_nm_d;
      exch_go_q  <= exch_go_d;
      cpu_id_q   <= cpu_id_d;
      cpu_amt_q  <= cpu_amt_d;
      exch_id_q  <= exch_id_d;
      exch_amt_q <= exch_amt_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      terr_q     <= terr_d;
    end
  end

  assign cpu_go             = cpu_go_q;
  assign cpu_new_max        = cpu_nm_q;
  assign exchange_go        = exch_go_q;
  assign cpu_client_id      = cpu_id_q;
  assign cpu_amount         = cpu_amt_q;
  assign exchange_client_id = exch_id_q;
  assign exchange_amount    = exch_amt_q;
  assign busy               = (state_q != IDLE);
  assign timeout_err        = terr_q;

endmodule

// File: doc/order_ingress_arbiter.md
# order_ingress_arbiter

Front-end stage feeding the risk-check top level. Buffers CPU order/limit requests and exchange cancellation messages in two small FIFOs and arbitrates between them. Presents exactly one request at a time on the top level's `cpu_go` / `exchange_go` interface, holding it until the stage signals completion. Exchange messages take priority so cancellations reach the downstream cache before new orders are risk-checked; a starvation guard bounds CPU wait.

## Interface
Parameters:
- `CPU_DEPTH`, 4: CPU FIFO entries (power of 2, ≥2)
- `EXCH_DEPTH`, 4: exchange FIFO entries (power of 2, ≥2)
- `STARVE_LIMIT`, 3: consecutive exchange grants allowed while CPU FIFO non-empty
- `TIMEOUT`, 16: cycles in WAIT before abandoning a request

Ports:
- `clk`  in  1  single clock, rising edge
- `HRESETn`  in  1  asynchronous, active-low reset
- `cpu_valid` / `cpu_ready`  in/out  1  CPU push handshake
- `cpu_client_id_i`  in  5  client index
- `cpu_amount_i`  in  32  order amount, or new max when `cpu_new_max_i`
- `cpu_new_max_i`  in  1  request is a limit update, not an order
- `exch_valid` / `exch_ready`  in/out  1  exchange push handshake
- `exch_client_id_i`  in  5;  `exch_amount_i`  in  16  cancelled amount
- `cpu_go`, `cpu_new_max`, `exchange_go`  out  1  request strobes to risk stage
- `cpu_client_id`, `exchange_client_id`  out  5;  `cpu_amount`  out  32;  `exchange_amount`  out  16
- `done`  in  1  risk stage finished current request
- `busy`  out  1  FSM not in IDLE
- `timeout_err`  out  1  sticky: a request timed out
- `cpu_count`  out  $clog2(CPU_DEPTH)+1;  `exch_count`  out  $clog2(EXCH_DEPTH)+1  FIFO occupancy

## Operation
- Push: accepted on a rising edge with `valid && ready`. `ready = !full`, combinational from count. A push while full is impossible by construction; `valid` without `ready` is ignored.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE → ISSUE: when either FIFO is non-empty. Pop the selected head into the output field registers.
  - ISSUE: exactly one `go` strobe high (`exchange_go`, or `cpu_go` with `cpu_new_max` copied from entry). ISSUE → WAIT unconditionally, unless `done`=1 in this cycle, then → IDLE.
  - WAIT: strobes low. → IDLE on `done`=1. Timeout counter increments each WAIT cycle; on reaching `TIMEOUT`, set `timeout_err` and → IDLE.
- Arbitration at IDLE grant:
  - exchange wins if non-empty, unless starve counter == `STARVE_LIMIT` and CPU FIFO non-empty.
  - Starve counter: +1 on exchange grant while CPU non-empty; cleared on CPU grant or whenever CPU FIFO is empty; saturates at `STARVE_LIMIT`.
- Output field registers hold the last granted values until the next grant. Fields of the non-selected source are unchanged.
- `done` outside ISSUE/WAIT is ignored.
- Push and pop on the same FIFO in the same edge are both honoured (count unchanged); pointers wrap modulo depth.

## Timing
- Reset, asynchronous: FSM IDLE, FIFOs empty, all strobes 0, all field outputs 0, counters 0, `timeout_err` 0, `busy` 0, `cpu_ready`/`exch_ready` 1. Reset mid-WAIT discards the in-flight request and all buffered entries.
- Push at edge E0 into empty idle arbiter: grant at E1, strobe high for cycle E1–E2, fields valid from E1.
- Minimum request spacing is 2 cycles (`done` in ISSUE); typical 3+.
- `go` is never high for more than one cycle per request; `cpu_go` and `exchange_go` are never high together.
- Timeout: `timeout_err` rises on the edge ending the `TIMEOUT`-th WAIT cycle.

## Structure
- Add to shared `cache_def` package:
  - `cpu_order_t` {client_id[4:0], amount[31:0], new_max}
  - `exch_msg_t` {client_id[4:0], amount[15:0]}
  - `ingress_state_t` enum {IDLE, ISSUE, WAIT}
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice with the packed struct widths.
- Arbiter, FSM, and counters live in the top of this block.

## Test plan
- Reset then push CPU {id 3, amount 100}, `done` after 2 WAIT cycles → `cpu_go` single pulse at E1, `cpu_client_id`=3, `cpu_amount`=100, `busy` low after `done`.
- Preload 5 exchange msgs and 2 CPU orders, `done` every ISSUE cycle → grant order EX,EX,EX,CPU,EX,EX,CPU.
- Fill CPU FIFO with 4 pushes while in WAIT → `cpu_ready`=0, `cpu_count`=4; 5th push not stored; after `done`, head pops and `cpu_ready` returns 1.
- Never assert `done` → `timeout_err`=1 after 16 WAIT cycles, FSM IDLE, next queued entry issued.
- Push CPU `cpu_new_max_i`=1, amount 5000 → `cpu_go`=1 with `cpu_new_max`=1, `exchange_go`=0.
- Assert `HRESETn`=0 mid-WAIT with 3 entries queued → all outputs return to reset values immediately, counts 0.
